// File: rtl/mcse_ami_egress.sv
// Egress arbiter and buffer: arbitrates NUM_CH producer channels into a circular
// FIFO of tagged result words that is presented to the AMI consumer.
module mcse_ami_egress #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 256,
  parameter int FIFO_DEPTH = 8,
  localparam int TAG_W     = (NUM_CH > 2) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_ready,
  input  logic                     arb_mode,
  output logic [DATA_W-1:0]        mcse_ami_out,
  output logic [TAG_W-1:0]         ami_tag,
  output logic                     ami_valid,
  input  logic                     ami_ack,
  output logic [CNT_W-1:0]         fifo_count,
  output logic                     ack_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
  logic [TAG_W-1:0]  mem_tag  [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [TAG_W-1:0]  last_granted;

  logic [NUM_CH-1:0] grant;
  logic [TAG_W-1:0]  grant_idx;
  logic [TAG_W-1:0]  idx;
  logic              found;
  logic [DATA_W-1:0] push_data;
  logic              full;
  logic              push;
  logic              pop;

  // Walk the channels in search order; fixed priority is the same walk starting at 0.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    found     = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (arb_mode)
        idx = TAG_W'(k);
      else
        idx = TAG_W'((32'(last_granted) + 32'd1 + k) % 32'(NUM_CH));
      if (!found && ch_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  always_comb begin
    push_data = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant[i])
        push_data = ch_data[i*DATA_W +: DATA_W];
    end
  end

  assign full         = (count == CNT_W'(FIFO_DEPTH));
  assign ch_ready     = full ? '0 : grant;
  assign push         = |ch_ready;
  assign ami_valid    = (count != '0);
  assign pop          = ami_valid & ami_ack;
  assign mcse_ami_out = mem_data[rd_ptr];
  assign ami_tag      = mem_tag[rd_ptr];
  assign fifo_count   = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      last_granted <= TAG_W'(NUM_CH - 1);
      ack_err      <= 1'b0;
      mem_data     <= '{default: '0};
      mem_tag      <= '{default: '0};
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= push_data;
        mem_tag[wr_ptr]  <= grant_idx;
        wr_ptr           <= wr_ptr + 1'b1;
        last_granted     <= grant_idx;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ami_ack && !ami_valid)
        ack_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mcse_ami_egress.sv
// Directed bench for mcse_ami_egress: stepwise vector table plus hand sequences
// for backpressure, ordering across pointer wrap, and reset/ack-error behaviour.
module tb_mcse_ami_egress;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    ch_valid;
  logic [1023:0] ch_data;
  logic [3:0]    ch_ready;
  logic          arb_mode;
  logic [255:0]  mcse_ami_out;
  logic [1:0]    ami_tag;
  logic          ami_valid;
  logic          ami_ack;
  logic [3:0]    fifo_count;
  logic          ack_err;

  int checks   = 0;
  int failures = 0;

  mcse_ami_egress #(.NUM_CH(4), .DATA_W(256), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_data(ch_data),
    .ch_ready(ch_ready), .arb_mode(arb_mode), .mcse_ami_out(mcse_ami_out),
    .ami_tag(ami_tag), .ami_valid(ami_valid), .ami_ack(ami_ack),
    .fifo_count(fifo_count), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic       mode;
    logic       ack;
    logic [3:0] exp_ready;
    logic       exp_valid;
    logic [1:0] exp_tag;
    logic [3:0] exp_count;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic [1:0]   tag;
    logic [255:0] data;
  } ent_t;

  vec_t tbl [19];
  ent_t q [$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] chan_word(input int i);
    return {32{8'hA3 + 8'(i)}};
  endfunction

  function automatic logic [255:0] uniq_word(input int id);
    return {8{32'hC0DE0000 + 32'(id)}};
  endfunction

  int           next_id;
  int           accepted;
  int           cur_id [4];
  logic [3:0]   loaded;
  logic [3:0]   pushed;

  initial begin
    //          rst   valid   md    ack   ready   vld   tag   cnt   err
    tbl[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b0};
    tbl[1]  = '{1'b0, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 4'd1, 1'b0};
    tbl[2]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 4'd1, 1'b0};
    tbl[3]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b0};
    tbl[4]  = '{1'b0, 4'b1111, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3, 4'd1, 1'b0};
    tbl[5]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0, 4'd1, 1'b0};
    tbl[6]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, 4'd1, 1'b0};
    tbl[7]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2, 4'd1, 1'b0};
    tbl[8]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 4'b1000, 1'b1, 2'd3, 4'd1, 1'b0};
    tbl[9]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0, 4'd1, 1'b0};
    tbl[10] = '{1'b0, 4'b1010, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1, 4'd1, 1'b0};
    tbl[11] = '{1'b0, 4'b1010, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1, 4'd1, 1'b0};
    tbl[12] = '{1'b0, 4'b1010, 1'b0, 1'b1, 4'b1000, 1'b1, 2'd3, 4'd1, 1'b0};
    tbl[13] = '{1'b0, 4'b1010, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, 4'd1, 1'b0};
    tbl[14] = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b0};
    tbl[15] = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b1};
    tbl[16] = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b0};
    tbl[17] = '{1'b0, 4'b1100, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2, 4'd1, 1'b0};
    tbl[18] = '{1'b0, 4'b0110, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd2, 4'd2, 1'b0};

    rst = 1'b1; ch_valid = '0; arb_mode = 1'b0; ami_ack = 1'b0;
    for (int i = 0; i < 4; i++) ch_data[i*256 +: 256] = chan_word(i);
    cyc();

    for (int i = 0; i < 19; i++) begin
      rst      = tbl[i].rst;
      ch_valid = tbl[i].valid;
      arb_mode = tbl[i].mode;
      ami_ack  = tbl[i].ack;
      #1;
      chk($sformatf("v%0d_ready", i), 256'(ch_ready), 256'(tbl[i].exp_ready));
      cyc();
      chk($sformatf("v%0d_count", i), 256'(fifo_count), 256'(tbl[i].exp_count));
      chk($sformatf("v%0d_valid", i), 256'(ami_valid), 256'(tbl[i].exp_valid));
      chk($sformatf("v%0d_err", i), 256'(ack_err), 256'(tbl[i].exp_err));
      if (tbl[i].exp_valid) begin
        chk($sformatf("v%0d_tag", i), 256'(ami_tag), 256'(tbl[i].exp_tag));
        chk($sformatf("v%0d_data", i), mcse_ami_out, chan_word(int'(tbl[i].exp_tag)));
      end else if (tbl[i].rst) begin
        chk($sformatf("v%0d_rst_data", i), mcse_ami_out, 256'(0));
        chk($sformatf("v%0d_rst_tag", i), 256'(ami_tag), 256'(0));
      end
    end

    // Fill to full, then one ack with a request still pending
    rst = 1'b1; ch_valid = '0; ami_ack = 1'b0; arb_mode = 1'b0;
    cyc();
    rst = 1'b0;
    ch_valid = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("fill%0d_ready", k), 256'(ch_ready), 256'(4'b0001));
      cyc();
      chk($sformatf("fill%0d_count", k), 256'(fifo_count), 256'(k + 1));
    end
    #1;
    chk("full_ready", 256'(ch_ready), 256'(4'b0000));
    cyc();
    chk("full_count", 256'(fifo_count), 256'(8));
    ami_ack = 1'b1;
    #1;
    chk("full_ack_ready", 256'(ch_ready), 256'(4'b0000));
    chk("full_ack_count", 256'(fifo_count), 256'(8));
    cyc();
    chk("after_ack_count", 256'(fifo_count), 256'(7));
    ami_ack = 1'b0;
    #1;
    chk("refill_ready", 256'(ch_ready), 256'(4'b0001));
    cyc();
    chk("refill_count", 256'(fifo_count), 256'(8));
    ch_valid = '0;

    // 20 unique words from all channels, random acks, scoreboard ordering
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    q.delete();
    next_id = 0;
    accepted = 0;
    for (int i = 0; i < 4; i++) begin
      cur_id[i] = next_id;
      next_id++;
      loaded[i] = 1'b1;
    end
    for (int c = 0; c < 400 && !(accepted == 20 && q.size() == 0); c++) begin
      for (int i = 0; i < 4; i++) begin
        ch_valid[i] = loaded[i];
        ch_data[i*256 +: 256] = uniq_word(cur_id[i]);
      end
      ami_ack = ($urandom_range(0, 2) != 0);
      #1;
      chk("ord_ready_onehot", 256'($countones(ch_ready) <= 1), 256'(1));
      pushed = ch_ready;
      if (ami_valid && ami_ack) begin
        if (q.size() == 0) begin
          chk("ord_spurious_valid", 256'(ami_valid), 256'(0));
        end else begin
          chk("ord_data", mcse_ami_out, q[0].data);
          chk("ord_tag", 256'(ami_tag), 256'(q[0].tag));
          void'(q.pop_front());
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (pushed[i]) begin
          q.push_back('{2'(i), uniq_word(cur_id[i])});
          accepted++;
          if (next_id < 20) begin
            cur_id[i] = next_id;
            next_id++;
          end else begin
            loaded[i] = 1'b0;
          end
        end
      end
      cyc();
      chk("ord_count", 256'(fifo_count), 256'(q.size()));
    end
    chk("ord_done", 256'(accepted == 20 && q.size() == 0), 256'(1));
    ch_valid = '0;
    ami_ack = 1'b0;

    // Reset flush with 5 buffered, ch_valid held across reset, then ack error
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) ch_data[i*256 +: 256] = chan_word(i);
    ch_valid = 4'b0010;
    for (int k = 0; k < 5; k++) cyc();
    chk("pre_rst_count", 256'(fifo_count), 256'(5));
    rst = 1'b1;
    cyc();
    chk("rst_count", 256'(fifo_count), 256'(0));
    chk("rst_valid", 256'(ami_valid), 256'(0));
    chk("rst_data", mcse_ami_out, 256'(0));
    chk("rst_tag", 256'(ami_tag), 256'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 256'(ch_ready), 256'(4'b0010));
    cyc();
    chk("post_rst_count", 256'(fifo_count), 256'(1));
    chk("post_rst_tag", 256'(ami_tag), 256'(1));
    chk("post_rst_data", mcse_ami_out, chan_word(1));
    ch_valid = '0;
    ami_ack = 1'b1;
    cyc();
    chk("drain_count", 256'(fifo_count), 256'(0));
    chk("drain_err", 256'(ack_err), 256'(0));
    cyc();
    chk("empty_ack_err", 256'(ack_err), 256'(1));
    ami_ack = 1'b0;
    cyc();
    cyc();
    chk("err_sticky", 256'(ack_err), 256'(1));
    rst = 1'b1;
    cyc();
    chk("err_cleared", 256'(ack_err), 256'(0));
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mcse_ami_egress.md
MCSE_AMI_EGRESS -- requirements
Module: mcse_ami_egress

Interface
REQ-001 Parameter NUM_CH, default 4: number of producer channels (SHA, Camellia, PUF, spare); range 2..16.
REQ-002 Parameter DATA_W, default 256: width of one result word on each channel and on the AMI output.
REQ-003 Parameter FIFO_DEPTH, default 8: egress buffer entries; power of two, >= 2.
REQ-004 Derived: TAG_W = max(1, clog2(NUM_CH)); CNT_W = clog2(FIFO_DEPTH)+1.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 ch_valid  input  NUM_CH  per-channel result-available flag.
REQ-009 ch_data  input  NUM_CH*DATA_W  packed results; channel i at [i*DATA_W +: DATA_W].
REQ-010 ch_ready  output  NUM_CH  per-channel accept; at most one bit high per cycle.
REQ-011 arb_mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-012 mcse_ami_out  output  DATA_W  head-of-buffer result word.
REQ-013 ami_tag  output  TAG_W  source channel index of mcse_ami_out.
REQ-014 ami_valid  output  1  head word present.
REQ-015 ami_ack  input  1  consumer acceptance; pops head when ami_valid high.
REQ-016 fifo_count  output  CNT_W  number of buffered entries, 0..FIFO_DEPTH.
REQ-017 ack_err  output  1  sticky flag: ami_ack seen while ami_valid low.

Function
REQ-018 Transfer from channel i occurs on a cycle where ch_valid[i] and ch_ready[i] are both high; the word and tag i are written to the buffer tail at that edge.
REQ-019 ch_ready is combinational: ch_ready[i] = grant[i] & ~full; grant is one-hot over requesting channels, all-zero when no ch_valid bit is set.
REQ-020 Round-robin: search starts at (last_granted+1) mod NUM_CH; last_granted updates only on an actual transfer.
REQ-021 Fixed priority: grant to lowest-index requester; last_granted still updates on transfer so a return to round-robin resumes fairly.
REQ-022 arb_mode is sampled each cycle, with no pipelining; a change affects the grant in the same cycle.
REQ-023 Producers hold ch_valid and ch_data stable until their transfer; the block does not register ch_data before acceptance.
REQ-024 Buffer: circular, read/write pointers wrap modulo FIFO_DEPTH; full when fifo_count == FIFO_DEPTH, empty when 0.
REQ-025 mcse_ami_out/ami_tag drive the head entry directly; ami_valid = (fifo_count != 0).
REQ-026 Latency: a word accepted at edge t into an empty buffer shows ami_valid = 1 from cycle t+1.
REQ-027 Pop: ami_valid & ami_ack at an edge advances the read pointer; the next entry, if any, is visible the following cycle.
REQ-028 Simultaneous push and pop: fifo_count is unchanged and both pointers advance.
REQ-029 Full: ch_ready is all-zero even if ami_ack is high in the same cycle; full-cycle bypass is not supported.
REQ-030 Empty: ami_ack is ignored for data and sets ack_err at the next edge; ack_err clears only on rst.
REQ-031 Words are delivered in acceptance order; no word is dropped or duplicated.

Reset
REQ-032 While rst is high at an edge: pointers = 0, fifo_count = 0, last_granted = NUM_CH-1 (channel 0 first in round-robin), ack_err = 0.
REQ-033 After reset, outputs are ami_valid = 0, mcse_ami_out = 0, ami_tag = 0 and ch_ready = 0; memory contents are zeroed on reset.
REQ-034 Reset mid-operation flushes all buffered words; nothing accepted before reset is presented afterward.
REQ-035 A ch_valid held across reset is accepted only after rst deasserts, subject to normal arbitration.

Verification (NUM_CH=4, DATA_W=256, FIFO_DEPTH=8)
REQ-036 Single word: ch_valid=4'b0100 with data 0xA5..A5, ami_ack=0 -> ch_ready=4'b0100 for one cycle, then ami_valid=1, tag=2, fifo_count=1.
REQ-037 Round-robin: all four ch_valid held, arb_mode=0, ami_ack=1 constantly -> ami_tag sequence 0,1,2,3,0,1...; each channel gets 1 of every 4 grants.
REQ-038 Fixed priority: ch_valid=4'b1010 held, arb_mode=1 -> only channel 1 is granted while it requests; switching to arb_mode=0 grants channel 3 next.
REQ-039 Full/backpressure: 9 requests with ami_ack=0 -> fifo_count reaches 8 and ch_ready=0; one ack with a request pending -> count stays 8 for that cycle, then rises again from 7.
REQ-040 Wrap and order: 20 words with random acks -> output order equals acceptance order across pointer wrap; fifo_count is never >8 and never negative.
REQ-041 Reset and ack error: rst is pulsed with 5 entries buffered -> next cycle fifo_count=0 and ami_valid=0; then ami_ack=1 while empty -> ack_err=1 and stays set until rst.
